chess_move_ctrl: RTL and testbench

//  Turn/move sequencer between the mouse path (cursor X/Y, button nibble) and the shared 64-entry board RAM.

---
 rtl/chess_pkg.sv | 28 ++
 rtl/pix_to_square.sv | 32 +++
 rtl/chess_move_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_chess_move_ctrl.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared types for the chess move controller and the board/colour-mapping path.
// Covers piece codes, square indices and controller state encoding.
package chess_pkg;

    typedef logic [3:0] piece_t;
    typedef logic [5:0] square_t;

    localparam piece_t EMPTY = 4'h0;
    localparam logic   WHITE = 1'b0;
    localparam logic   BLACK = 1'b1;

    typedef enum logic [3:0] {
        CtrlIdle   = 4'd0,
        CtrlRdSrc  = 4'd1,
        CtrlChkSrc = 4'd2,
        CtrlSel    = 4'd3,
        CtrlRdDst  = 4'd4,
        CtrlChkDst = 4'd5,
        CtrlWrDst  = 4'd6,
        CtrlWrSrc  = 4'd7,
        CtrlDone   = 4'd8
    } ctrl_state_t;

    function automatic logic piece_colour(piece_t p);
        return p[3];
    endfunction

endpackage

// File: rtl/pix_to_square.sv
// Maps a pixel coordinate to a board square with threshold compares (no divider).
// Also flags whether the coordinate lies on the board at all.
module pix_to_square
    import chess_pkg::*;
#(
    parameter int unsigned BOARD_X0 = 80,
    parameter int unsigned BOARD_Y0 = 0,
    parameter int unsigned SQ_SIZE  = 60
) (
    input  logic [9:0] x,
    input  logic [9:0] y,
    output square_t    square,
    output logic       on_board
);

    logic [2:0] col;
    logic [2:0] row;

    always_comb begin
        col = 3'd0;
        row = 3'd0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (32'(x) >= BOARD_X0 + k * SQ_SIZE) col = col + 3'd1;
            if (32'(y) >= BOARD_Y0 + k * SQ_SIZE) row = row + 3'd1;
        end
    end

    assign square   = {row, col};
    assign on_board = (32'(x) >= BOARD_X0) && (32'(x) < BOARD_X0 + 8 * SQ_SIZE) &&
                      (32'(y) >= BOARD_Y0) && (32'(y) < BOARD_Y0 + 8 * SQ_SIZE);

endmodule

// File: rtl/chess_move_ctrl.sv
// Turn/move sequencer: turns mouse clicks into source/destination selection and commits
// each move to the shared board RAM over a req/gnt port.
module chess_move_ctrl
    import chess_pkg::*;
#(
    parameter int unsigned BOARD_X0 = 80,
    parameter int unsigned BOARD_Y0 = 0,
    parameter int unsigned SQ_SIZE  = 60
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [9:0] mouse_x,
    input  logic [9:0] mouse_y,
    input  logic [3:0] click,
    output logic       mem_req,
    output logic       mem_we,
    output logic [5:0] mem_addr,
    output logic [3:0] mem_wdata,
    input  logic       mem_gnt,
    input  logic       mem_rvalid,
    input  logic [3:0] mem_rdata,
    output logic       sel_valid,
    output logic [5:0] sel_sq,
    output logic       turn,
    output logic       move_done,
    output logic       illegal,
    output logic [5:0] status
);

    ctrl_state_t state_q;
    logic [1:0]  sync1_q, sync2_q, sync3_q;
    logic        left_edge, right_edge;
    square_t     click_sq;
    logic        click_on_board;
    square_t     src_sq_q, dst_sq_q;
    piece_t      src_piece_q, rd_piece_q;

    // Only the left/right buttons are used; the other bits are tied off here.
    logic unused_click;
    assign unused_click = ^click[3:2];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            sync3_q <= 2'b00;
        end else begin
            sync1_q <= click[1:0];
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign left_edge  = sync2_q[0] & ~sync3_q[0];
    assign right_edge = sync2_q[1] & ~sync3_q[1];

    // The cursor square is captured into src/dst registers on the edge that uses it.
    pix_to_square #(
        .BOARD_X0 (BOARD_X0),
        .BOARD_Y0 (BOARD_Y0),
        .SQ_SIZE  (SQ_SIZE)
    ) u_pix_to_square (
        .x        (mouse_x),
        .y        (mouse_y),
        .square   (click_sq),
        .on_board (click_on_board)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= CtrlIdle;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= EMPTY;
            sel_valid   <= 1'b0;
            sel_sq      <= '0;
            turn        <= WHITE;
            move_done   <= 1'b0;
            illegal     <= 1'b0;
            src_sq_q    <= '0;
            dst_sq_q    <= '0;
            src_piece_q <= EMPTY;
            rd_piece_q  <= EMPTY;
        end else begin
            move_done <= 1'b0;
            illegal   <= 1'b0;
            case (state_q)
                CtrlIdle: begin
                    if (left_edge && click_on_board) begin
                        src_sq_q <= click_sq;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= click_sq;
                        state_q  <= CtrlRdSrc;
                    end
                end
                // mem_req low here means the read was granted and data is pending.
                CtrlRdSrc: begin
                    if (mem_req) begin
                        if (mem_gnt) mem_req <= 1'b0;
                    end else if (mem_rvalid) begin
                        rd_piece_q <= mem_rdata;
                        state_q    <= CtrlChkSrc;
                    end
                end
                CtrlChkSrc: begin
                    if (rd_piece_q != EMPTY && piece_colour(rd_piece_q) == turn) begin
                        src_piece_q <= rd_piece_q;
                        sel_valid   <= 1'b1;
                        sel_sq      <= src_sq_q;
                        state_q     <= CtrlSel;
                    end else begin
                        illegal <= 1'b1;
                        state_q <= CtrlIdle;
                    end
                end
                CtrlSel: begin
                    if (right_edge) begin
                        sel_valid <= 1'b0;
                        sel_sq    <= '0;
                        state_q   <= CtrlIdle;
                    end else if (left_edge && click_on_board) begin
                        if (click_sq == src_sq_q) begin
                            sel_valid <= 1'b0;
                            sel_sq    <= '0;
                            state_q   <= CtrlIdle;
                        end else begin
                            dst_sq_q <= click_sq;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= click_sq;
                            state_q  <= CtrlRdDst;
                        end
                    end
                end
                CtrlRdDst: begin
                    if (mem_req) begin
                        if (mem_gnt) mem_req <= 1'b0;
                    end else if (mem_rvalid) begin
                        rd_piece_q <= mem_rdata;
                        state_q    <= CtrlChkDst;
                    end
                end
                CtrlChkDst: begin
                    if (rd_piece_q == EMPTY || piece_colour(rd_piece_q) != turn) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= dst_sq_q;
                        mem_wdata <= src_piece_q;
                        state_q   <= CtrlWrDst;
                    end else begin
                        // Own piece on the destination: it becomes the new source.
                        src_sq_q    <= dst_sq_q;
                        src_piece_q <= rd_piece_q;
                        sel_sq      <= dst_sq_q;
                        state_q     <= CtrlSel;
                    end
                end
                CtrlWrDst: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state_q <= CtrlWrSrc;
                    end
                end
                CtrlWrSrc: begin
                    if (!mem_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= src_sq_q;
                        mem_wdata <= EMPTY;
                    end else if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state_q <= CtrlDone;
                    end
                end
                CtrlDone: begin
                    move_done <= 1'b1;
                    turn      <= ~turn;
                    sel_valid <= 1'b0;
                    sel_sq    <= '0;
                    state_q   <= CtrlIdle;
                end
                default: state_q <= CtrlIdle;
            endcase
        end
    end

    assign status = {turn, 1'b0, state_q};

endmodule

// File: tb/tb_chess_move_ctrl.sv
// Self-checking bench for chess_move_ctrl: RAM responder, directed scenarios and a
// randomized click sequence checked against a rules-level model of the game flow.
module tb_chess_move_ctrl;

    localparam int X0 = 80;
    localparam int Y0 = 0;
    localparam int SQ = 60;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [9:0] mouse_x, mouse_y;
    logic [3:0] click;
    logic       mem_req, mem_we;
    logic [5:0] mem_addr;
    logic [3:0] mem_wdata;
    logic       mem_gnt, mem_rvalid;
    logic [3:0] mem_rdata;
    logic       sel_valid;
    logic [5:0] sel_sq;
    logic       turn, move_done, illegal;
    logic [5:0] status;

    always #20 Clk = ~Clk;

    chess_move_ctrl #(.BOARD_X0(X0), .BOARD_Y0(Y0), .SQ_SIZE(SQ)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .mouse_x    (mouse_x),
        .mouse_y    (mouse_y),
        .click      (click),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .sel_valid  (sel_valid),
        .sel_sq     (sel_sq),
        .turn       (turn),
        .move_done  (move_done),
        .illegal    (illegal),
        .status     (status)
    );

    logic [3:0] board [64];
    int         rd_addr_q[$];
    int         wr_addr_q[$];
    int         wr_data_q[$];
    int         ill_cnt = 0;
    int         done_cnt = 0;
    bit         req_seen = 0;
    bit         hold_wr = 0;
    int         block_addr = -1;
    int         tests = 0;
    int         fails = 0;

    // Board RAM model: gnt one cycle after req, rvalid two cycles after gnt.
    initial begin
        logic [5:0] g_addr;
        logic       g_we;
        logic [3:0] g_wdata;
        int         rv_cnt;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; rv_cnt = 0;
        g_addr = 0; g_we = 0; g_wdata = 0;
        forever begin
            @(posedge Clk); #1;
            if (!Reset_n) begin
                mem_gnt = 0; mem_rvalid = 0; rv_cnt = 0;
            end else begin
                mem_rvalid = 0;
                if (rv_cnt == 1) begin
                    mem_rvalid = 1; mem_rdata = board[g_addr]; rv_cnt = 0;
                end
                if (mem_gnt) begin
                    mem_gnt = 0;
                    tests++;
                    if (mem_req !== 1'b0) begin
                        fails++;
                        $display("FAIL req_drop: mem_req=%0b after gnt, required 0", mem_req);
                    end
                    if (g_we) begin
                        board[g_addr] = g_wdata;
                        wr_addr_q.push_back(int'(g_addr));
                        wr_data_q.push_back(int'(g_wdata));
                    end else begin
                        rd_addr_q.push_back(int'(g_addr));
                        rv_cnt = 1;
                    end
                end else if (mem_req === 1'b1 && !(mem_we && hold_wr) &&
                             !(mem_we && int'(mem_addr) == block_addr)) begin
                    mem_gnt = 1; g_addr = mem_addr; g_we = mem_we; g_wdata = mem_wdata;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge Clk);
            if (illegal === 1'b1) ill_cnt++;
            if (move_done === 1'b1) done_cnt++;
            if (mem_req === 1'b1) req_seen = 1;
        end
    end

    function automatic int sq_x(int sq);
        return X0 + (sq % 8) * SQ + 30;
    endfunction

    function automatic int sq_y(int sq);
        return Y0 + (sq / 8) * SQ + 30;
    endfunction

    task automatic apply_reset();
        Reset_n = 0; click = 0; hold_wr = 0; block_addr = -1;
        repeat (3) @(negedge Clk);
        Reset_n = 1;
        @(negedge Clk);
    endtask

    task automatic clear_logs();
        rd_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    endtask

    task automatic clear_board();
        for (int i = 0; i < 64; i++) board[i] = 4'h0;
    endtask

    task automatic do_click(input logic [1:0] btn, input int x, input int y);
        mouse_x = 10'(x); mouse_y = 10'(y);
        @(negedge Clk);
        click = {2'b00, btn};
        repeat (3) @(negedge Clk);
        click = 4'h0;
        repeat (30) @(negedge Clk);
    endtask

    task automatic test_reset();
        mouse_x = 0; mouse_y = 0; click = 0;
        apply_reset();
        tests++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== 12'h0) begin
            fails++;
            $display("FAIL reset_mem: got %h required 0", {mem_req, mem_we, mem_addr, mem_wdata});
        end
        tests++;
        if ({sel_valid, sel_sq, turn, move_done, illegal} !== 10'h0) begin
            fails++;
            $display("FAIL reset_sel: got %h required 0", {sel_valid, sel_sq, turn, move_done, illegal});
        end
        tests++;
        if (status !== 6'h0) begin
            fails++;
            $display("FAIL reset_status: got %h required 0", status);
        end
    endtask

    task automatic test_move();
        int d0;
        apply_reset(); clear_board(); clear_logs();
        board[8] = 4'h1;
        d0 = done_cnt;
        do_click(2'b01, 110, 70);
        do_click(2'b01, 110, 130);
        tests++;
        if (rd_addr_q.size() != 2 || rd_addr_q[0] != 8 || rd_addr_q[1] != 16) begin
            fails++;
            $display("FAIL move_reads: got %p required '{8,16}", rd_addr_q);
        end
        tests++;
        if (wr_addr_q.size() != 2 || wr_addr_q[0] != 16 || wr_data_q[0] != 1 ||
            wr_addr_q[1] != 8 || wr_data_q[1] != 0) begin
            fails++;
            $display("FAIL move_writes: got addr %p data %p required 16<=1, 8<=0",
                     wr_addr_q, wr_data_q);
        end
        tests++;
        if (done_cnt - d0 != 1) begin
            fails++;
            $display("FAIL move_done_pulse: got %0d cycles required 1", done_cnt - d0);
        end
        tests++;
        if (turn !== 1'b1 || status !== 6'b100000) begin
            fails++;
            $display("FAIL move_turn: got turn=%0b status=%h required turn=1 status=20", turn, status);
        end
    endtask

    task automatic test_illegal_src();
        int i0;
        apply_reset(); clear_board(); clear_logs();
        board[48] = 4'h9;
        i0 = ill_cnt;
        do_click(2'b01, sq_x(48), sq_y(48));
        tests++;
        if (ill_cnt - i0 != 1) begin
            fails++;
            $display("FAIL illegal_pulse: got %0d cycles required 1", ill_cnt - i0);
        end
        tests++;
        if (wr_addr_q.size() != 0 || sel_valid !== 1'b0 || status[3:0] !== 4'h0) begin
            fails++;
            $display("FAIL illegal_state: writes=%0d sel_valid=%0b state=%h required 0,0,0",
                     wr_addr_q.size(), sel_valid, status[3:0]);
        end
    endtask

    task automatic test_reselect();
        clear_board(); clear_logs();
        board[8] = 4'h1; board[9] = 4'h2;
        do_click(2'b01, sq_x(8), sq_y(8));
        tests++;
        if (sel_valid !== 1'b1 || sel_sq !== 6'd8) begin
            fails++;
            $display("FAIL select_src: got valid=%0b sq=%0d required 1,8", sel_valid, sel_sq);
        end
        do_click(2'b01, sq_x(9), sq_y(9));
        tests++;
        if (sel_valid !== 1'b1 || sel_sq !== 6'd9 || wr_addr_q.size() != 0) begin
            fails++;
            $display("FAIL reselect: got valid=%0b sq=%0d writes=%0d required 1,9,0",
                     sel_valid, sel_sq, wr_addr_q.size());
        end
        do_click(2'b10, sq_x(20), sq_y(20));
        tests++;
        if (sel_valid !== 1'b0 || status[3:0] !== 4'h0) begin
            fails++;
            $display("FAIL cancel: got valid=%0b state=%h required 0,0", sel_valid, status[3:0]);
        end
    endtask

    task automatic test_boundary();
        int i0, d0;
        clear_board(); clear_logs();
        board[8] = 4'h1; board[9] = 4'h1;
        i0 = ill_cnt; d0 = done_cnt;
        @(negedge Clk); req_seen = 0;
        do_click(2'b01, 20, 70);
        do_click(2'b01, 560, 70);
        tests++;
        if (req_seen || rd_addr_q.size() != 0 || ill_cnt != i0 || done_cnt != d0) begin
            fails++;
            $display("FAIL off_board: req_seen=%0b reads=%0d pulses=%0d required 0,0,0",
                     req_seen, rd_addr_q.size(), (ill_cnt - i0) + (done_cnt - d0));
        end
        do_click(2'b01, 139, 70);
        tests++;
        if (rd_addr_q.size() != 1 || rd_addr_q[0] != 8 || sel_sq !== 6'd8) begin
            fails++;
            $display("FAIL x139_col0: got reads=%p sel_sq=%0d required '{8}, 8", rd_addr_q, sel_sq);
        end
        do_click(2'b10, 139, 70);
        do_click(2'b01, 140, 70);
        tests++;
        if (rd_addr_q.size() != 2 || rd_addr_q[1] != 9 || sel_sq !== 6'd9) begin
            fails++;
            $display("FAIL x140_col1: got reads=%p sel_sq=%0d required '{8,9}, 9", rd_addr_q, sel_sq);
        end
        do_click(2'b10, 140, 70);
    endtask

    task automatic test_gnt_stall();
        logic [11:0] ref_v;
        int          d0;
        apply_reset(); clear_board(); clear_logs();
        board[8] = 4'h1; board[40] = 4'h2;
        hold_wr = 1;
        d0 = done_cnt;
        do_click(2'b01, sq_x(8), sq_y(8));
        do_click(2'b01, sq_x(16), sq_y(16));
        ref_v = {mem_req, mem_we, mem_addr, mem_wdata};
        tests++;
        if (ref_v !== {1'b1, 1'b1, 6'd16, 4'h1}) begin
            fails++;
            $display("FAIL stall_req: got %h required %h", ref_v, {1'b1, 1'b1, 6'd16, 4'h1});
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 1) begin
                mouse_x = 10'(sq_x(40)); mouse_y = 10'(sq_y(40)); click = 4'h1;
            end
            if (i == 5) click = 4'h0;
            @(negedge Clk);
            tests++;
            if ({mem_req, mem_we, mem_addr, mem_wdata} !== ref_v) begin
                fails++;
                $display("FAIL stall_stable[%0d]: got %h required %h", i,
                         {mem_req, mem_we, mem_addr, mem_wdata}, ref_v);
            end
        end
        hold_wr = 0;
        repeat (30) @(negedge Clk);
        tests++;
        if (rd_addr_q.size() != 2 || wr_addr_q.size() != 2 || done_cnt - d0 != 1 ||
            turn !== 1'b1 || sel_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_commit: reads=%0d writes=%0d done=%0d turn=%0b sel=%0b required 2,2,1,1,0",
                     rd_addr_q.size(), wr_addr_q.size(), done_cnt - d0, turn, sel_valid);
        end
    endtask

    task automatic test_reset_mid_move();
        apply_reset(); clear_board(); clear_logs();
        board[8] = 4'h1;
        block_addr = 8;
        do_click(2'b01, sq_x(8), sq_y(8));
        do_click(2'b01, sq_x(16), sq_y(16));
        tests++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b1, 6'd8}) begin
            fails++;
            $display("FAIL wrsrc_pending: got %h required %h", {mem_req, mem_we, mem_addr},
                     {1'b1, 1'b1, 6'd8});
        end
        #5 Reset_n = 0;
        #1;
        tests++;
        if (mem_req !== 1'b0) begin
            fails++;
            $display("FAIL async_reset_req: got %0b required 0", mem_req);
        end
        repeat (2) @(negedge Clk);
        Reset_n = 1; block_addr = -1;
        @(negedge Clk);
        tests++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, sel_valid, sel_sq, turn, move_done, illegal,
             status} !== 28'h0) begin
            fails++;
            $display("FAIL post_reset_outputs: got %h required 0",
                     {mem_req, mem_we, mem_addr, mem_wdata, sel_valid, sel_sq, turn, move_done,
                      illegal, status});
        end
        tests++;
        if (board[16] !== 4'h1 || board[8] !== 4'h1) begin
            fails++;
            $display("FAIL half_commit: got b16=%h b8=%h required 1,1", board[16], board[8]);
        end
    endtask

    task automatic test_random();
        logic [3:0] m_board [64];
        bit         m_sel, m_turn, on;
        int         m_src, x, y, msq, i0, d0, w0, e_ill, e_done, e_wr, diff;
        logic [1:0] btn;
        logic [3:0] p;
        apply_reset(); clear_logs();
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 1) == 0) board[i] = 4'h0;
            else board[i] = {1'($urandom_range(0, 1)), 3'($urandom_range(1, 6))};
            m_board[i] = board[i];
        end
        m_sel = 0; m_turn = 0; m_src = 0;
        for (int n = 0; n < 60; n++) begin
            btn = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b01;
            if ($urandom_range(0, 3) == 0) begin
                x = $urandom_range(0, 719); y = $urandom_range(0, 519);
            end else begin
                msq = $urandom_range(0, 63);
                x = X0 + (msq % 8) * SQ + $urandom_range(0, SQ - 1);
                y = Y0 + (msq / 8) * SQ + $urandom_range(0, SQ - 1);
            end
            on  = (x >= X0) && (x < X0 + 8 * SQ) && (y >= Y0) && (y < Y0 + 8 * SQ);
            msq = on ? ((y - Y0) / SQ) * 8 + (x - X0) / SQ : 0;
            e_ill = 0; e_done = 0; e_wr = 0;
            if (btn == 2'b10) begin
                m_sel = 0;
            end else if (on) begin
                if (!m_sel) begin
                    p = m_board[msq];
                    if (p != 0 && p[3] == m_turn) begin m_sel = 1; m_src = msq; end
                    else e_ill = 1;
                end else if (msq == m_src) begin
                    m_sel = 0;
                end else begin
                    p = m_board[msq];
                    if (p == 0 || p[3] != m_turn) begin
                        m_board[msq] = m_board[m_src]; m_board[m_src] = 4'h0;
                        m_turn = ~m_turn; m_sel = 0; e_done = 1; e_wr = 2;
                    end else begin
                        m_src = msq;
                    end
                end
            end
            i0 = ill_cnt; d0 = done_cnt; w0 = wr_addr_q.size();
            do_click(btn, x, y);
            tests++;
            if (ill_cnt - i0 != e_ill || done_cnt - d0 != e_done || wr_addr_q.size() - w0 != e_wr) begin
                fails++;
                $display("FAIL rnd_events[%0d]: got ill=%0d done=%0d wr=%0d required %0d,%0d,%0d",
                         n, ill_cnt - i0, done_cnt - d0, wr_addr_q.size() - w0, e_ill, e_done, e_wr);
            end
            tests++;
            if (turn !== m_turn || sel_valid !== m_sel || (m_sel && sel_sq !== 6'(m_src))) begin
                fails++;
                $display("FAIL rnd_sel[%0d]: got turn=%0b valid=%0b sq=%0d required %0b,%0b,%0d",
                         n, turn, sel_valid, sel_sq, m_turn, m_sel, m_src);
            end
            diff = 0;
            for (int i = 0; i < 64; i++) if (board[i] !== m_board[i]) diff++;
            tests++;
            if (diff != 0) begin
                fails++;
                $display("FAIL rnd_board[%0d]: got %0d differing squares required 0", n, diff);
            end
        end
    endtask

    initial begin
        Reset_n = 0; click = 0; mouse_x = 0; mouse_y = 0;
        clear_board();
        test_reset();
        test_move();
        test_illegal_src();
        test_reselect();
        test_boundary();
        test_gnt_stall();
        test_reset_mid_move();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
